memdump_axi: RTL and testbench

Memory readback engine that reads a block of 32-bit words from the memory endpoint over the AXI-lite read channels and streams them out as raw bytes on a UART transmit line. It is the return path for the UART program loader: the host triggers a dump of a given region and verifies loaded code or inspects results. It sits on `clk`/`rst` alongside the loader and shares the loader's bit timing.

---
 rtl/memdump_axi.sv | 173 +++++++++++++++++
 tb/tb_memdump_axi.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memdump_axi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memdump_axi
// Function : Reads a block of 32-bit words over AXI-lite read channels and
//            streams them LSB-byte first as 8N1 UART bytes on utx.
// Revision : 1.0  initial release
// ============================================================================
module memdump_axi #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd83,
    parameter int          DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [15:0]           word_count,
    output logic [31:0]           axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic                  utx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] c_STOP_IDX = 4'd9;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_addr;
    logic [15:0]           r_remaining;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [15:0]           r_clk_cnt;
    logic [3:0]            r_bit_idx;
    logic [1:0]            r_byte_idx;

    logic                  w_bit_end;
    logic                  w_byte_end;
    logic                  w_word_end;
    logic [3:0]            w_bit_m1;
    logic                  w_tx_bit;

    assign w_bit_end  = (r_clk_cnt == CLKS_PER_BIT - 16'd1);
    assign w_byte_end = w_bit_end && (r_bit_idx == c_STOP_IDX);
    assign w_word_end = w_byte_end && (r_byte_idx == 2'd3);
    assign w_bit_m1   = r_bit_idx - 4'd1;

    // Frame position 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
    always_comb begin
        w_tx_bit = 1'b1;
        if (r_bit_idx == 4'd0) begin
            w_tx_bit = 1'b0;
        end else if (r_bit_idx != c_STOP_IDX) begin
            w_tx_bit = r_shift[w_bit_m1[2:0]];
        end
    end

    assign axi_araddr = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        utx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count != 16'd0) ? S_AR : S_DONE;
                end
            end
            S_AR: begin
                axi_arvalid = 1'b1;
                busy        = 1'b1;
                if (axi_arready) begin
                    w_next = S_R;
                end
            end
            S_R: begin
                axi_rready = 1'b1;
                busy       = 1'b1;
                if (axi_rvalid) begin
                    w_next = S_TX;
                end
            end
            S_TX: begin
                busy = 1'b1;
                utx  = w_tx_bit;
                // The last word is the one that drains the counter to zero.
                if (w_word_end) begin
                    w_next = (r_remaining == 16'd1) ? S_DONE : S_AR;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_shift     <= '0;
            r_clk_cnt   <= 16'd0;
            r_bit_idx   <= 4'd0;
            r_byte_idx  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= word_count;
                    end
                end
                S_R: begin
                    if (axi_rvalid) begin
                        r_shift    <= axi_rdata;
                        r_clk_cnt  <= 16'd0;
                        r_bit_idx  <= 4'd0;
                        r_byte_idx <= 2'd0;
                    end
                end
                S_TX: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= 16'd0;
                        if (r_bit_idx == c_STOP_IDX) begin
                            r_bit_idx  <= 4'd0;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= r_shift >> 8;
                            if (r_byte_idx == 2'd3) begin
                                r_remaining <= r_remaining - 16'd1;
                                r_addr      <= r_addr + 32'd4;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memdump_axi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memdump_axi
// Function : Self-checking bench for memdump_axi with an AXI slave model,
//            a UART receiver and a byte/address reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_memdump_axi;

    localparam logic [15:0] CPB  = 16'd83;
    localparam int          CPBI = 83;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        utx;
    logic        busy;
    logic        done;

    memdump_axi #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .axi_araddr (axi_araddr),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata  (axi_rdata),
        .axi_rvalid (axi_rvalid),
        .axi_rready (axi_rready),
        .utx        (utx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory contents seen by the slave
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_BEEF;
    endfunction

    // AXI-lite read slave with programmable wait states
    int          ar_delay = 0;
    int          r_delay  = 0;
    logic [31:0] ar_q[$];
    logic [31:0] last_addr = 32'd0;

    initial begin
        int ar_w;
        int r_w;
        ar_w = 0;
        r_w  = 0;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            axi_arready = 1'b0;
            axi_rvalid  = 1'b0;
            axi_rdata   = $urandom;
            if (rst) begin
                ar_w = 0;
                r_w  = 0;
            end else begin
                if (axi_arvalid) begin
                    if (ar_w < ar_delay) ar_w++;
                    else begin
                        axi_arready = 1'b1;
                        ar_q.push_back(axi_araddr);
                        last_addr = axi_araddr;
                        ar_w = 0;
                    end
                end
                if (axi_rready) begin
                    if (r_w < r_delay) r_w++;
                    else begin
                        axi_rvalid = 1'b1;
                        axi_rdata  = mem_rd(last_addr);
                        r_w = 0;
                    end
                end
            end
        end
    end

    // Activity monitors
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    logic        done_prev_busy = 1'b0;
    int          tx_first = -1;
    int          utx_low_cnt = 0;
    int          ar_run = 0;
    int          ar_run_last = 0;
    int          r_run = 0;
    int          r_run_last = 0;
    int          ar_unstable = 0;
    logic        prev_busy = 1'b0;
    logic        prev_arvalid = 1'b0;
    logic [31:0] prev_araddr = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc       = cyc;
                done_busy      = busy;
                done_prev_busy = prev_busy;
            end
            if (utx === 1'b0) begin
                utx_low_cnt++;
                if (tx_first < 0) tx_first = cyc;
            end
            if (axi_arvalid) ar_run++;
            else if (ar_run > 0) begin ar_run_last = ar_run; ar_run = 0; end
            if (axi_rready) r_run++;
            else if (r_run > 0) begin r_run_last = r_run; r_run = 0; end
            if (axi_arvalid && prev_arvalid && axi_araddr !== prev_araddr) ar_unstable++;
            prev_busy    = busy;
            prev_arvalid = axi_arvalid;
            prev_araddr  = axi_araddr;
        end
    end

    // UART receiver sampling at mid-bit
    logic [7:0] rx_q[$];
    int         frame_err = 0;

    initial begin
        logic [7:0] b;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst && utx === 1'b0) begin
                repeat (CPBI / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPBI) @(negedge clk);
                    b[i] = utx;
                end
                repeat (CPBI) @(negedge clk);
                if (utx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic clear_mon();
        ar_q.delete();
        rx_q.delete();
        done_cnt       = 0;
        done_cyc       = 0;
        done_busy      = 1'b0;
        done_prev_busy = 1'b0;
        tx_first       = -1;
        utx_low_cnt    = 0;
        ar_run_last    = 0;
        r_run_last     = 0;
        ar_unstable    = 0;
        frame_err      = 0;
    endtask

    task automatic run_dump(input logic [31:0] base, input int n, input int ard,
                            input int rd, input int extra_at, input string tag);
        logic [31:0] exp_addr[$];
        logic [7:0]  exp_bytes[$];
        logic [31:0] a;
        logic [31:0] o;
        int          bound;
        logic        got;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            exp_addr.push_back(a);
            if (!mem.exists(a)) mem[a] = $urandom;
            for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(mem[a] >> (8 * k)));
        end
        ar_delay = ard;
        r_delay  = rd;
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = 16'(n);
        @(negedge clk);
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = 16'($urandom);
        bound = n * (40 * CPBI + ard + rd + 10) + 20;
        got   = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk);
            if (c == extra_at) begin
                start      = 1'b1;
                base_addr  = 32'hBAD0_0000;
                word_count = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0) got = 1'b1;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_at_done"}, 32'(done_busy), 32'd0);
        check({tag, " ar_count"}, 32'(ar_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            o = 'x;
            if (i < ar_q.size()) o = ar_q[i];
            check($sformatf("%s araddr[%0d]", tag, i), o, exp_addr[i]);
        end
        check({tag, " byte_count"}, 32'(rx_q.size()), 32'(4 * n));
        for (int i = 0; i < 4 * n; i++) begin
            o = 'x;
            if (i < rx_q.size()) o = {24'd0, rx_q[i]};
            check($sformatf("%s byte[%0d]", tag, i), o, {24'd0, exp_bytes[i]});
        end
        check({tag, " stop_bits"}, 32'(frame_err), 32'd0);
        check({tag, " araddr_stable"}, 32'(ar_unstable), 32'd0);
    endtask

    initial begin
        logic got_low;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = 32'd0;
        word_count = 16'd0;
        repeat (3) @(negedge clk);
        check("reset utx", 32'(utx), 32'd1);
        check("reset arvalid", 32'(axi_arvalid), 32'd0);
        check("reset rready", 32'(axi_rready), 32'd0);
        check("reset araddr", axi_araddr, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word
        mem[32'h100] = 32'h1234_5678;
        run_dump(32'h100, 1, 0, 0, -1, "single");
        check("single serial_time", 32'(done_cyc - tx_first), 32'd3320);
        check("single busy_before_done", 32'(done_prev_busy), 32'd1);

        // Multi-word
        run_dump(32'h100, 3, 0, 0, -1, "multi");

        // Backpressure: 5 cycles arready low, 7 cycles rvalid delayed
        run_dump(32'h300, 1, 5, 7, -1, "bp");
        check("bp arvalid_cycles", 32'(ar_run_last), 32'd6);
        check("bp rready_cycles", 32'(r_run_last), 32'd8);

        // Zero count
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = 32'h500;
        word_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero done_next_cycle", 32'(done), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero done_one_cycle", 32'(done), 32'd0);
        check("zero busy_after", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("zero done_count", 32'(done_cnt), 32'd1);
        check("zero utx_quiet", 32'(utx_low_cnt), 32'd0);
        check("zero no_ar", 32'(ar_q.size()), 32'd0);

        // Start pulsed mid-dump is ignored
        run_dump(32'h600, 2, 1, 1, 500, "busystart");

        // Address wrap-around
        run_dump(32'hFFFF_FFFC, 2, 0, 0, -1, "wrap");

        // Reset during data bit 3 of the second byte (that bit is 0)
        mem[32'h700] = 32'h0000_00F0;
        ar_delay = 0;
        r_delay  = 0;
        clear_mon();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = 32'h700;
        word_count = 16'd1;
        @(negedge clk);
        start   = 1'b0;
        got_low = 1'b0;
        for (int c = 0; c < 100 && !got_low; c++) begin
            @(negedge clk);
            if (utx === 1'b0) got_low = 1'b1;
        end
        check("rstmid start_bit_seen", 32'(got_low), 32'd1);
        repeat (14 * CPBI + CPBI / 2) @(negedge clk);
        check("rstmid utx_before", 32'(utx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid utx", 32'(utx), 32'd1);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid arvalid", 32'(axi_arvalid), 32'd0);
        check("rstmid rready", 32'(axi_rready), 32'd0);
        rst = 1'b0;
        repeat (12 * CPBI) @(negedge clk);
        run_dump(32'h100, 1, 0, 0, -1, "post_rst");

        // Randomized dumps
        for (int r = 0; r < 2; r++) begin
            run_dump($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 2)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1,
                     $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
